// File: rtl/deal_sequencer.sv
// Deal sequencer for one blackjack round: runs the opening four-card deal, then
// serves player/split/dealer draw requests one card-source transaction at a time.
module deal_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_round,
   input  logic       req_player,
   input  logic       req_split,
   input  logic       req_dealer,
   input  logic       card_valid,
   input  logic [3:0] card_rank,
   output logic       card_req,
   output logic       deal_valid,
   output logic [1:0] deal_dest,
   output logic [5:0] deal_card,
   output logic       init_done,
   output logic       busy,
   output logic [3:0] cards_dealt,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE,
      INIT_FETCH,
      INIT_DELIVER,
      READY,
      FETCH,
      DELIVER
   } state_t;

   localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
   localparam logic [7:0] RetryLimit   = 8'(MAX_RETRY);

   state_t     r_state;
   state_t     w_nextState;
   logic [1:0] r_initIdx;
   logic [7:0] r_timeout;
   logic [7:0] r_retry;
   logic [5:0] r_card;
   logic [1:0] r_dest;
   logic [2:0] r_pend;
   logic [3:0] r_cardsDealt;
   logic       r_err;
   logic       r_initDone;

   logic       w_fetching;
   logic       w_delivering;
   logic       w_rankOk;
   logic       w_goodCard;
   logic       w_badCard;
   logic       w_abort;
   logic       w_stayFetch;
   logic [7:0] w_timeoutInc;
   logic [7:0] w_retryInc;
   logic [2:0] w_reqs;
   logic [2:0] w_serveMask;
   logic [1:0] w_grant;
   logic [5:0] w_value;

   assign w_fetching   = (r_state == INIT_FETCH) || (r_state == FETCH);
   assign w_delivering = (r_state == INIT_DELIVER) || (r_state == DELIVER);
   assign w_rankOk     = (card_rank >= 4'd1) && (card_rank <= 4'd13);
   assign w_goodCard   = w_fetching && card_valid && w_rankOk;
   assign w_badCard    = w_fetching && card_valid && !w_rankOk;
   assign w_timeoutInc = r_timeout + 8'd1;
   assign w_retryInc   = r_retry + {7'd0, w_badCard};
   // A good card in the final allowed cycle still wins over either abort cause.
   assign w_abort      = w_fetching && !w_goodCard &&
                         ((w_retryInc == RetryLimit) || (w_timeoutInc == TimeoutLimit));
   assign w_stayFetch  = w_fetching && !w_goodCard && !w_abort;
   assign w_value      = (card_rank > 4'd10) ? 6'd10 : {2'b00, card_rank};

   // Pending bits: bit 0 player, bit 1 split, bit 2 dealer (index equals dest code).
   assign w_reqs      = ((r_state == READY) || (r_state == FETCH) || (r_state == DELIVER)) ?
                        {req_dealer, req_split, req_player} : 3'b000;
   assign w_serveMask = (r_state == DELIVER) ? (3'b001 << r_dest) : 3'b000;

   always_comb begin
      w_grant = 2'b00;
      if (r_pend[0])      w_grant = 2'b00;
      else if (r_pend[1]) w_grant = 2'b01;
      else if (r_pend[2]) w_grant = 2'b10;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:         if (start_round) w_nextState = INIT_FETCH;
         INIT_FETCH: begin
            if (w_goodCard)   w_nextState = INIT_DELIVER;
            else if (w_abort) w_nextState = IDLE;
         end
         INIT_DELIVER: w_nextState = (r_initIdx == 2'd3) ? READY : INIT_FETCH;
         READY:        if (|r_pend) w_nextState = FETCH;
         FETCH: begin
            if (w_goodCard)   w_nextState = DELIVER;
            else if (w_abort) w_nextState = IDLE;
         end
         DELIVER:      w_nextState = READY;
         default:      w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_initIdx    <= 2'd0;
         r_timeout    <= 8'd0;
         r_retry      <= 8'd0;
         r_card       <= 6'd0;
         r_dest       <= 2'd0;
         r_pend       <= 3'b000;
         r_cardsDealt <= 4'd0;
         r_err        <= 1'b0;
         r_initDone   <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_timeout <= w_stayFetch ? w_timeoutInc : 8'd0;
         r_retry   <= w_stayFetch ? w_retryInc : 8'd0;
         r_pend    <= w_abort ? 3'b000 : ((r_pend & ~w_serveMask) | w_reqs);

         if (w_goodCard) r_card <= w_value;
         if ((r_state == READY) && (|r_pend)) r_dest <= w_grant;
         if (w_delivering && (r_cardsDealt != 4'hF)) r_cardsDealt <= r_cardsDealt + 4'd1;
         if (w_abort) r_err <= 1'b1;

         if (r_state == INIT_DELIVER) begin
            if (r_initIdx == 2'd3) r_initDone <= 1'b1;
            else                   r_initIdx  <= r_initIdx + 2'd1;
         end

         if ((r_state == IDLE) && start_round) begin
            r_initIdx    <= 2'd0;
            r_cardsDealt <= 4'd0;
            r_err        <= 1'b0;
            r_initDone   <= 1'b0;
         end
      end
   end

   assign card_req    = w_fetching;
   assign deal_valid  = w_delivering;
   assign deal_dest   = (r_state == INIT_DELIVER) ? {r_initIdx[0], 1'b0} :
                        (r_state == DELIVER)      ? r_dest : 2'b00;
   assign deal_card   = w_delivering ? r_card : 6'd0;
   assign init_done   = r_initDone;
   assign busy        = (r_state != IDLE) && (r_state != READY);
   assign cards_dealt = r_cardsDealt;
   assign err         = r_err;

endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer: directed round scenarios plus random
// traffic, all compared every cycle against a behavioural model of the round.
module tb_deal_sequencer;

   localparam int TIMEOUT_CYCLES = 255;
   localparam int MAX_RETRY      = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_round;
   logic       req_player;
   logic       req_split;
   logic       req_dealer;
   logic       card_valid;
   logic [3:0] card_rank;
   logic       card_req;
   logic       deal_valid;
   logic [1:0] deal_dest;
   logic [5:0] deal_card;
   logic       init_done;
   logic       busy;
   logic [3:0] cards_dealt;
   logic       err;

   always #5 clk = ~clk;

   deal_sequencer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_round(start_round),
      .req_player(req_player),
      .req_split(req_split),
      .req_dealer(req_dealer),
      .card_valid(card_valid),
      .card_rank(card_rank),
      .card_req(card_req),
      .deal_valid(deal_valid),
      .deal_dest(deal_dest),
      .deal_card(deal_card),
      .init_done(init_done),
      .busy(busy),
      .cards_dealt(cards_dealt),
      .err(err)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model of the round: where we are, what is owed, what was dealt.
   typedef enum int {P_IDLE, P_INIT_FETCH, P_INIT_DELIVER, P_READY, P_FETCH, P_DELIVER} phase_t;
   phase_t   mPhase;
   int       mIdx, mAge, mBad, mCard, mDest, mCount;
   bit [2:0] mPend;
   bit       mErr, mDone;

   task automatic modelReset();
      mPhase = P_IDLE;
      mIdx = 0; mAge = 0; mBad = 0; mCard = 0; mDest = 0; mCount = 0;
      mPend = 3'b000; mErr = 1'b0; mDone = 1'b0;
   endtask

   task automatic modelStep(input bit rst, input bit st, input bit rp, input bit rs,
                            input bit rd, input bit cv, input int rank);
      phase_t   old;
      bit [2:0] wanted;
      bit       aborted;
      bit       found;
      old     = mPhase;
      wanted  = {rd, rs, rp};
      aborted = 1'b0;
      found   = 1'b0;
      if (rst) begin
         modelReset();
         return;
      end
      case (old)
         P_IDLE: if (st) begin
            mPhase = P_INIT_FETCH;
            mIdx = 0; mCount = 0; mErr = 1'b0; mDone = 1'b0; mAge = 0; mBad = 0;
         end
         P_INIT_FETCH, P_FETCH: begin
            if (cv && rank >= 1 && rank <= 13) begin
               mCard  = (rank > 10) ? 10 : rank;
               mPhase = (old == P_FETCH) ? P_DELIVER : P_INIT_DELIVER;
            end else begin
               mAge++;
               if (cv) mBad++;
               if (mAge >= TIMEOUT_CYCLES || mBad >= MAX_RETRY) begin
                  mErr = 1'b1; mPhase = P_IDLE; aborted = 1'b1;
               end
            end
         end
         P_INIT_DELIVER: begin
            mCount = (mCount < 15) ? mCount + 1 : 15;
            if (mIdx == 3) begin
               mDone = 1'b1; mPhase = P_READY;
            end else begin
               mIdx++; mPhase = P_INIT_FETCH; mAge = 0; mBad = 0;
            end
         end
         P_READY: begin
            for (int i = 0; i < 3; i++) begin
               if (!found && mPend[i]) begin
                  found = 1'b1; mDest = i; mPhase = P_FETCH; mAge = 0; mBad = 0;
               end
            end
         end
         P_DELIVER: begin
            mCount = (mCount < 15) ? mCount + 1 : 15;
            mPend[mDest] = 1'b0;
            mPhase = P_READY;
         end
         default: mPhase = P_IDLE;
      endcase
      if (old == P_READY || old == P_FETCH || old == P_DELIVER) mPend = mPend | wanted;
      if (aborted) mPend = 3'b000;
   endtask

   // Packed view: {card_req, deal_valid, deal_dest, deal_card, init_done, busy, cards_dealt, err}
   function automatic logic [16:0] modelOut();
      logic       req, dv, bsy;
      logic [1:0] dest;
      logic [5:0] card;
      req  = (mPhase == P_INIT_FETCH) || (mPhase == P_FETCH);
      dv   = (mPhase == P_INIT_DELIVER) || (mPhase == P_DELIVER);
      dest = 2'b00;
      if (mPhase == P_INIT_DELIVER) dest = (mIdx % 2 == 1) ? 2'b10 : 2'b00;
      else if (mPhase == P_DELIVER) dest = 2'(mDest);
      card = dv ? 6'(mCard) : 6'd0;
      bsy  = !((mPhase == P_IDLE) || (mPhase == P_READY));
      return {req, dv, dest, card, mDone, bsy, 4'(mCount), mErr};
   endfunction

   function automatic logic [16:0] dutVec();
      return {card_req, deal_valid, deal_dest, deal_card, init_done, busy, cards_dealt, err};
   endfunction

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: got 'h%0h, expected 'h%0h", name, $time, actual, expected);
      end
   endtask

   task automatic checkOutput();
      checkVal("cycle{req,dv,dest,card,done,busy,cnt,err}", dutVec(), modelOut());
   endtask

   task automatic applyStimulus(input bit rst, input bit st, input bit rp, input bit rs,
                                input bit rd, input bit cv, input int rank);
      @(negedge clk);
      reset = rst; start_round = st;
      req_player = rp; req_split = rs; req_dealer = rd;
      card_valid = cv; card_rank = 4'(rank);
      modelStep(rst, st, rp, rs, rd, cv, rank);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idleTick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cardTick(input int rank);
      applyStimulus(0, 0, 0, 0, 0, 1, rank);
   endtask

   task automatic quickInit();
      int r[4];
      r = '{2, 3, 4, 6};
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cardTick(r[i]);
         idleTick();
      end
   endtask

   initial begin
      int ranks[4];
      int vals[4];
      int dests[4];
      int strobes;
      logic [16:0] e;
      bit rst, st, rp, rs, rd, cv;
      int rank, pick;

      ranks = '{5, 12, 1, 9};
      vals  = '{5, 10, 1, 9};
      dests = '{0, 2, 0, 2};
      reset = 1'b0; start_round = 1'b0; req_player = 1'b0; req_split = 1'b0;
      req_dealer = 1'b0; card_valid = 1'b0; card_rank = 4'd0;
      modelReset();

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkVal("resetOutputs", dutVec(), 0);

      // Opening deal with one idle cycle before each card answer.
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkVal("initCardReq", card_req, 1);
      for (int i = 0; i < 4; i++) begin
         idleTick();
         cardTick(ranks[i]);
         checkVal("initDealValid", deal_valid, 1);
         checkVal("initDest", deal_dest, dests[i]);
         checkVal("initCard", deal_card, vals[i]);
         checkVal("initReqDropped", card_req, 0);
         idleTick();
      end
      checkVal("initDone", init_done, 1);
      checkVal("initCount", cards_dealt, 4);
      checkVal("readyBusy", busy, 0);

      // Player and dealer requested together: player first.
      applyStimulus(0, 0, 1, 0, 1, 0, 0);
      checkVal("pendNotYetGranted", card_req, 0);
      idleTick();
      checkVal("grantLatency", card_req, 1);
      cardTick(7);
      checkVal("prioFirstDest", deal_dest, 0);
      checkVal("prioFirstCard", deal_card, 7);
      idleTick();
      idleTick();
      cardTick(13);
      checkVal("prioSecondDest", deal_dest, 2);
      checkVal("faceValue", deal_card, 10);
      idleTick();
      checkVal("countAfterPrio", cards_dealt, 6);

      // Two split pulses during a player fetch yield one split card.
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      idleTick();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      cardTick(3);
      checkVal("splitTestPlayerDest", deal_dest, 0);
      idleTick();
      idleTick();
      cardTick(11);
      checkVal("splitDest", deal_dest, 1);
      checkVal("splitCard", deal_card, 10);
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         idleTick();
         strobes += int'(deal_valid) + int'(card_req);
      end
      checkVal("noDuplicateSplit", strobes, 0);
      checkVal("countAfterSplit", cards_dealt, 8);

      // Retry exhaustion during the opening deal, then restart.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cardTick(0);
      cardTick(15);
      checkVal("retryNotYet", err, 0);
      cardTick(0);
      checkVal("retryErr", err, 1);
      checkVal("retryReqLow", card_req, 0);
      checkVal("retryNoDeal", deal_valid, 0);
      checkVal("retryIdle", busy, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkVal("restartErrCleared", err, 0);
      checkVal("restartCardReq", card_req, 1);
      cardTick(8);
      checkVal("restartDest", deal_dest, 0);
      checkVal("restartCard", deal_card, 8);

      // Card source silent for the whole timeout window in FETCH.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      quickInit();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      idleTick();
      for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) idleTick();
      checkVal("timeoutLastReqCycle", card_req, 1);
      checkVal("timeoutNotYet", err, 0);
      idleTick();
      checkVal("timeoutErr", err, 1);
      checkVal("timeoutReqLow", card_req, 0);
      checkVal("timeoutIdle", busy, 0);

      // Reset while a fetch is in flight and a split is pending.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      quickInit();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      idleTick();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkVal("midFetchReq", card_req, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkVal("midFetchReset", dutVec(), 0);
      quickInit();
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         idleTick();
         strobes += int'(card_req);
      end
      checkVal("pendClearedByReset", strobes, 0);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         e    = modelOut();
         rst  = ($urandom_range(0, 499) == 0);
         st   = ($urandom_range(0, 15) == 0);
         rp   = ($urandom_range(0, 9) == 0);
         rs   = ($urandom_range(0, 9) == 0);
         rd   = ($urandom_range(0, 9) == 0);
         cv   = e[16] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            pick = $urandom_range(0, 2);
            rank = (pick == 0) ? 0 : (pick == 1) ? 14 : 15;
         end else begin
            rank = $urandom_range(1, 13);
         end
         applyStimulus(rst, st, rp, rs, rd, cv, rank);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Sequences the shared card source for one blackjack round and routes each drawn card to the player hand, split hand or dealer hand.
- On `start_round`, deals the opening four cards in order player, dealer, player, dealer.
- Afterwards, arbitrates pending draw requests from the player, split and dealer logic, with one card source transaction at a time.
- Sits between the random card generator and the `blackjack` scoring datapath.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for `card_valid` per request (1..255, 8-bit counter).
- MAX_RETRY, 3: invalid ranks tolerated per card before `err` is raised.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_round  input  1  one-cycle pulse; begins opening deal
- req_player  input  1  pulse; request one card for player hand
- req_split  input  1  pulse; request one card for split hand
- req_dealer  input  1  pulse; request one card for dealer hand
- card_valid  input  1  card source: `card_rank` valid this cycle
- card_rank  input  4  card source rank, 1..13 legal
- card_req  output  1  request to card source, held until `card_valid`
- deal_valid  output  1  one-cycle strobe: `deal_card` / `deal_dest` valid
- deal_dest  output  2  00 player, 01 split, 10 dealer, 11 unused
- deal_card  output  6  card value 1..10
- init_done  output  1  high after opening four cards delivered, until next `start_round`/reset
- busy  output  1  high in every state except IDLE and READY
- cards_dealt  output  4  cards delivered this round, saturates at 15
- err  output  1  sticky; set on timeout or retry exhaustion, cleared by reset or `start_round`

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; pending bits, counters and init index cleared.
- States: IDLE, INIT_FETCH, INIT_DELIVER, READY, FETCH, DELIVER.
- IDLE:
  - `start_round` → INIT_FETCH, with init index = 0, `cards_dealt` = 0, `err` = 0, `init_done` = 0.
  - `req_*` pulses are ignored (not latched).
- INIT_FETCH / FETCH:
  - `card_req` = 1; timeout counter increments each cycle.
  - `card_valid` with rank 1..13 → capture, go to the matching DELIVER state next cycle; `card_req` drops that same next cycle.
  - Rank 0 or 14..15: discard, increment retry count, keep `card_req` high.
  - Retry count reaching MAX_RETRY → `err` = 1, IDLE.
  - Timeout counter reaching TIMEOUT_CYCLES without a valid card → `err` = 1, IDLE.
  - Both counters clear on entry to a FETCH state.
- Value mapping: ranks 1..10 → same value; ranks 11..13 → 10. Ace is delivered as 1; soft-ace handling belongs to the scorer.
- INIT_DELIVER:
  - `deal_valid` = 1 for exactly one cycle.
  - `deal_dest` = 00 for init index 0 and 2; 10 for index 1 and 3.
  - `cards_dealt` += 1.
  - Index < 3 → index += 1, INIT_FETCH.
  - Index = 3 → `init_done` = 1, READY.
- Pending bits:
  - `pend_p`, `pend_s`, `pend_d` are set by `req_*` pulses in READY, FETCH and DELIVER.
  - Duplicate pulses while a bit is set are absorbed.
  - A bit is cleared on the DELIVER cycle serving it; a request pulse arriving on that same cycle for the same destination re-sets it (set wins).
- READY:
  - Fixed priority player > split > dealer.
  - If any pending bit is set, latch the winner as destination and go to FETCH next cycle; otherwise stay.
  - `busy` = 0.
- DELIVER: one-cycle `deal_valid` to the latched destination; `cards_dealt` += 1 (saturating); → READY.
- Latency:
  - Request pulse in READY → `card_req` rises 2 cycles later (pending set, then grant).
  - `card_valid` → `deal_valid` next cycle.
- `start_round` outside IDLE: ignored. A new round requires reset or a return to IDLE. An `err` abort also clears the pending bits.
- `card_valid` outside FETCH states: ignored.

Test Plan:
- Reset, `start_round`, card source answers 1 cycle after each `card_req` with ranks 5,12,1,9 → `deal_valid` ×4, dest 00,10,00,10, cards 5,10,1,9; `init_done` = 1; `cards_dealt` = 4.
- READY: `req_dealer` and `req_player` pulsed the same cycle → player served first, then dealer; two `deal_valid` strobes, dest 00 then 10.
- `req_split` pulsed twice while a player card is in FETCH → exactly one split card delivered after the player card.
- Card source returns rank 0, 15, 0 during init → `err` = 1, state IDLE, no `deal_valid`; then `start_round` → `err` cleared, opening deal restarts.
- `card_valid` withheld for 255 cycles in FETCH → `err` = 1 at cycle 255, `card_req` = 0, IDLE.
- Reset asserted mid-FETCH with `card_req` high → next cycle all outputs 0, state IDLE, pending bits cleared.
